fetch_stage: RTL and testbench

- Instruction-fetch front end of the PA_RISC pipeline, directly upstream of decode and the register file.
- Owns the PCFront/PCBack program-counter queue and drives the instruction-memory address.
- Latches fetched instructions into the IF/ID pipeline register, with stall, delayed-branch redirect and delay-slot nullification.
- Maintains a fetched-instruction counter for bring-up benches.

---
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch front end of the PA_RISC pipeline. It keeps the
// PCFront/PCBack program-counter queue and drives the instruction memory from
// PCFront. Each fetched word is captured in the IF/ID pipeline register. The
// stage supports stalls, delayed-branch redirects and squashing of the delay
// slot. It also counts the live instructions it hands to decode.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high; overrides every other input
//   le_pc          PC queue load enable (0 = stall, PCs hold)
//   le_ifid        IF/ID load enable (0 = IF/ID and fetch_count hold)
//   branch_taken   branch resolved taken in ID this cycle
//   branch_target  branch destination; the low two bits are forced to 00
//   nullify_next   squash the word being latched into IF/ID this cycle
//   imem_data      instruction word read combinationally at imem_addr
//   imem_addr      instruction memory address (= PCFront, combinational)
//   pc_front_out   PCFront register
//   pc_back_out    PCBack register
//   ifid_instr     IF/ID instruction word
//   ifid_pc        address the IF/ID instruction was fetched from
//   ifid_valid     IF/ID holds a live (non-nullified) instruction
//   fetch_count    number of valid instructions latched into IF/ID (wraps)
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0800_0240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        le_pc,
  input  logic        le_ifid,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        nullify_next,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_front_out,
  output logic [31:0] pc_back_out,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic        ifid_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_front;
  logic [31:0] pc_back;
  logic [31:0] aligned_target;

  // Branch targets are always word aligned, so the low two bits are dropped.
  assign aligned_target = {branch_target[31:2], 2'b00};

  // The memory is addressed directly from PCFront. This is the only
  // combinational path through the stage.
  assign imem_addr    = pc_front;
  assign pc_front_out = pc_front;
  assign pc_back_out  = pc_back;

  // PC queue. During a stall both registers hold, and a pending branch is
  // ignored until the stall releases. The hazard unit keeps branch_taken
  // asserted until then. When a branch is taken, the word fetched this cycle
  // is the delay slot. That word still flows into IF/ID through the block
  // below.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_front <= RESET_PC;
      pc_back  <= RESET_PC + 32'd4;
    end else if (le_pc) begin
      if (branch_taken) begin
        pc_front <= aligned_target;
        pc_back  <= aligned_target + 32'd4;
      end else begin
        pc_front <= pc_back;
        pc_back  <= pc_back + 32'd4;
      end
    end
  end

  // IF/ID register and fetch counter. A nullified slot still records the PC
  // it came from. It does not count as a fetched instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_instr  <= NOP_INSTR;
      ifid_pc     <= 32'd0;
      ifid_valid  <= 1'b0;
      fetch_count <= 32'd0;
    end else if (le_ifid) begin
      ifid_pc <= pc_front;
      if (nullify_next) begin
        ifid_instr <= NOP_INSTR;
        ifid_valid <= 1'b0;
      end else begin
        ifid_instr  <= imem_data;
        ifid_valid  <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. A sequence of directed steps covers
// reset, free-run, branches, stalls, address wrap and a mid-stream reset.
// A randomized phase follows. Every cycle is compared against a small
// behavioural model of the fetch stage. Instruction memory is modelled as a
// pure function of the address: either word = address, or a scrambled word.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0800_0240;

  logic        clk;
  logic        reset;
  logic        le_pc;
  logic        le_ifid;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        nullify_next;
  logic [31:0] imem_data;
  logic [31:0] imem_addr;
  logic [31:0] pc_front_out;
  logic [31:0] pc_back_out;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  logic        mem_mode;

  // Expected architectural state of the stage.
  logic [31:0] exp_front;
  logic [31:0] exp_back;
  logic [31:0] exp_instr;
  logic [31:0] exp_pc;
  logic        exp_valid;
  logic [31:0] exp_count;

  int check_count;
  int pass_count;
  int fail_count;

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .le_pc        (le_pc),
    .le_ifid      (le_ifid),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .nullify_next (nullify_next),
    .imem_data    (imem_data),
    .imem_addr    (imem_addr),
    .pc_front_out (pc_front_out),
    .pc_back_out  (pc_back_out),
    .ifid_instr   (ifid_instr),
    .ifid_pc      (ifid_pc),
    .ifid_valid   (ifid_valid),
    .fetch_count  (fetch_count)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: identity for the directed steps, scrambled for the
  // random phase.
  function automatic logic [31:0] mem_word(input logic [31:0] addr, input logic mode);
    if (mode)
      return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    return addr;
  endfunction

  assign imem_data = mem_word(imem_addr, mem_mode);

  // Advance the reference model by one clock edge, using the inputs that
  // were applied for that edge.
  task automatic modelStep();
    logic [31:0] fetched;
    logic [31:0] tgt;
    if (reset) begin
      exp_front = RESET_PC;
      exp_back  = RESET_PC + 32'd4;
      exp_instr = NOP_INSTR;
      exp_pc    = 32'd0;
      exp_valid = 1'b0;
      exp_count = 32'd0;
    end else begin
      fetched = mem_word(exp_front, mem_mode);
      if (le_ifid) begin
        exp_pc = exp_front;
        if (nullify_next) begin
          exp_instr = NOP_INSTR;
          exp_valid = 1'b0;
        end else begin
          exp_instr = fetched;
          exp_valid = 1'b1;
          exp_count = exp_count + 32'd1;
        end
      end
      if (le_pc) begin
        if (branch_taken) begin
          tgt       = branch_target & 32'hFFFF_FFFC;
          exp_front = tgt;
          exp_back  = tgt + 32'd4;
        end else begin
          exp_front = exp_back;
          exp_back  = exp_back + 32'd4;
        end
      end
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic checkOutput(input string tag);
    checkValue({tag, ".imem_addr"},   imem_addr,    exp_front);
    checkValue({tag, ".pc_front"},    pc_front_out, exp_front);
    checkValue({tag, ".pc_back"},     pc_back_out,  exp_back);
    checkValue({tag, ".ifid_instr"},  ifid_instr,   exp_instr);
    checkValue({tag, ".ifid_pc"},     ifid_pc,      exp_pc);
    checkValue({tag, ".ifid_valid"},  {31'd0, ifid_valid}, {31'd0, exp_valid});
    checkValue({tag, ".fetch_count"}, fetch_count,  exp_count);
  endtask

  // Drive one cycle's inputs, clock an edge, update the model, then sample
  // the outputs 1 unit after the edge.
  task automatic applyStimulus(input string tag, input logic rst, input logic lp,
                               input logic li, input logic bt,
                               input logic [31:0] tgt, input logic nul);
    reset         = rst;
    le_pc         = lp;
    le_ifid       = li;
    branch_taken  = bt;
    branch_target = tgt;
    nullify_next  = nul;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    check_count   = 0;
    pass_count    = 0;
    fail_count    = 0;
    mem_mode      = 1'b0;
    reset         = 1'b1;
    le_pc         = 1'b0;
    le_ifid       = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    nullify_next  = 1'b0;
    exp_front     = 32'd0;
    exp_back      = 32'd0;
    exp_instr     = 32'd0;
    exp_pc        = 32'd0;
    exp_valid     = 1'b0;
    exp_count     = 32'd0;

    $display("[TB] reset state");
    applyStimulus("reset0", 1, 1, 1, 0, 32'd0, 0);
    applyStimulus("reset1", 1, 1, 1, 1, 32'h80, 0);
    checkValue("reset.front_const", pc_front_out, 32'h0);
    checkValue("reset.back_const",  pc_back_out,  32'h4);
    checkValue("reset.instr_const", ifid_instr,   32'h0800_0240);

    $display("[TB] free run");
    applyStimulus("run1", 0, 1, 1, 0, 32'd0, 0);
    checkValue("run1.front_const", pc_front_out, 32'd4);
    checkValue("run1.instr_const", ifid_instr,   32'd0);
    checkValue("run1.valid_const", {31'd0, ifid_valid}, 32'd1);
    applyStimulus("run2", 0, 1, 1, 0, 32'd0, 0);
    checkValue("run2.front_const", pc_front_out, 32'd8);
    checkValue("run2.instr_const", ifid_instr,   32'd4);
    applyStimulus("run3", 0, 1, 1, 0, 32'd0, 0);
    checkValue("run3.front_const", pc_front_out, 32'd12);
    checkValue("run3.instr_const", ifid_instr,   32'd8);
    checkValue("run3.count_const", fetch_count,  32'd3);

    $display("[TB] branch with live delay slot");
    applyStimulus("br.rst", 1, 1, 1, 0, 32'd0, 0);
    applyStimulus("br.a", 0, 1, 1, 0, 32'd0, 0);
    applyStimulus("br.b", 0, 1, 1, 0, 32'd0, 0);
    applyStimulus("br.take", 0, 1, 1, 1, 32'h40, 0);
    checkValue("br.front_const", pc_front_out, 32'h40);
    checkValue("br.back_const",  pc_back_out,  32'h44);
    checkValue("br.slot_const",  ifid_instr,   32'h8);
    applyStimulus("br.next", 0, 1, 1, 0, 32'd0, 0);
    checkValue("br.target_const", ifid_instr, 32'h40);

    $display("[TB] branch with nullified delay slot");
    applyStimulus("brn.rst", 1, 1, 1, 0, 32'd0, 0);
    applyStimulus("brn.a", 0, 1, 1, 0, 32'd0, 0);
    applyStimulus("brn.b", 0, 1, 1, 0, 32'd0, 0);
    applyStimulus("brn.take", 0, 1, 1, 1, 32'h40, 1);
    checkValue("brn.instr_const", ifid_instr,  32'h0800_0240);
    checkValue("brn.pc_const",    ifid_pc,     32'h8);
    checkValue("brn.count_const", fetch_count, 32'd2);
    checkValue("brn.front_const", pc_front_out, 32'h40);

    $display("[TB] stall");
    applyStimulus("st.rst", 1, 1, 1, 0, 32'd0, 0);
    for (int i = 0; i < 4; i++) applyStimulus("st.run", 0, 1, 1, 0, 32'd0, 0);
    checkValue("st.front_const", pc_front_out, 32'h10);
    applyStimulus("st.hold0", 0, 0, 0, 1, 32'h200, 1);
    applyStimulus("st.hold1", 0, 0, 0, 0, 32'h300, 0);
    applyStimulus("st.hold2", 0, 0, 0, 1, 32'h400, 1);
    checkValue("st.frozen_front", pc_front_out, 32'h10);
    applyStimulus("st.release", 0, 1, 1, 0, 32'd0, 0);
    checkValue("st.release_front", pc_front_out, 32'h14);

    $display("[TB] address wrap and target alignment");
    applyStimulus("wr.br", 0, 1, 1, 1, 32'hFFFF_FFFC, 0);
    applyStimulus("wr.run", 0, 1, 1, 0, 32'd0, 0);
    checkValue("wr.front_const", pc_front_out, 32'h0);
    applyStimulus("wr.align", 0, 1, 1, 1, 32'h43, 0);
    checkValue("wr.align_const", pc_front_out, 32'h40);

    $display("[TB] mid-stream reset");
    applyStimulus("mr.rst", 1, 1, 1, 0, 32'd0, 0);
    for (int i = 0; i < 5; i++) applyStimulus("mr.run", 0, 1, 1, 0, 32'd0, 0);
    checkValue("mr.count5", fetch_count, 32'd5);
    applyStimulus("mr.hit", 1, 1, 1, 1, 32'h80, 0);
    checkValue("mr.front_const", pc_front_out, RESET_PC);
    checkValue("mr.count_const", fetch_count,  32'd0);
    checkValue("mr.instr_const", ifid_instr,   32'h0800_0240);

    $display("[TB] randomized phase");
    mem_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 3) == 0),
                    $urandom(),
                    ($urandom_range(0, 5) == 0));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
